// File: rtl/sqrt_from_location_if.sv
// Request/response bundle for the fixed-point square-root unit.
//   start    : request pulse, sampled on rising clk edges
//   radicand : unsigned Q(WIDTH-FRAC).FRAC operand
//   location : leading-bit seed, ceil(p/2) of the integer part's MSB index
//   busy     : high while the root is being resolved
//   done     : one-cycle pulse, root valid
//   root     : unsigned Q(WIDTH-FRAC).FRAC square root
// master = requester, slave = the square-root unit.
interface sqrt_from_location_if #(
  parameter int WIDTH = 12
);
  logic             start;
  logic [WIDTH-1:0] radicand;
  logic [5:0]       location;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] root;

  modport master (output start, radicand, location, input busy, done, root);
  modport slave  (input start, radicand, location, output busy, done, root);
endinterface

// File: rtl/sqrt_from_location.sv
// Bit-serial fixed-point square root: root = floor(sqrt(radicand << FRAC)).
// The search starts at bit s = min(location + FRAC, RMAX), so small operands
// finish early. The first ITER cycle registers the widened comparison target;
// each following ITER cycle resolves one root bit, giving done s+2 edges after
// the accepting edge.
//   clk  : clock, all state on its rising edge
//   rst_ : synchronous active-high reset (wins over start)
//   bus  : slave side of sqrt_from_location_if (start/radicand/location in,
//          busy/done/root out)
module sqrt_from_location #(
  parameter int WIDTH = 12,
  parameter int FRAC  = 4
) (
  input logic                  clk,
  input logic                  rst_,
  sqrt_from_location_if.slave  bus
);
  localparam int RMAX = (WIDTH + FRAC + 1) / 2 - 1;  // top root bit index
  localparam int RW   = RMAX + 1;                    // root bits
  localparam int PW   = 2 * RW;                      // trial-square width
  localparam int IW   = (RMAX > 0) ? $clog2(RMAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t          state_reg, state_next;
  logic [WIDTH-1:0] rad_reg;
  logic [PW-1:0]   target_reg;
  logic [RW-1:0]   acc_reg;
  logic [IW-1:0]   idx_reg;
  logic            prime_reg;   // set for the target-forming first ITER cycle

  logic            accept;
  logic [7:0]      loc_sum;
  logic [IW-1:0]   s_start;
  logic [RW-1:0]   trial;
  logic [PW-1:0]   trial_sq;

  assign accept = bus.start && (state_reg == IDLE || state_reg == DONE);

  // Seed index, clamped so an oversized location cannot overrun the root width.
  always_comb begin
    loc_sum = 8'(bus.location) + 8'(FRAC);
    s_start = (loc_sum > 8'(RMAX)) ? IW'(RMAX) : IW'(loc_sum);
  end

  always_comb begin
    trial    = acc_reg | (RW'(1) << idx_reg);
    trial_sq = PW'(trial) * PW'(trial);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst_) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = ITER;
      ITER:    if (!prime_reg && idx_reg == '0) state_next = DONE;
      DONE:    state_next = bus.start ? ITER : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy = (state_reg == ITER);
    bus.done = (state_reg == DONE);
  end

  // The accumulator doubles as the result register: it is frozen outside
  // ITER, so root holds from DONE until the next accepted start.
  assign bus.root = WIDTH'(acc_reg);

  // Datapath
  always_ff @(posedge clk) begin
    if (rst_) begin
      rad_reg    <= '0;
      target_reg <= '0;
      acc_reg    <= '0;
      idx_reg    <= '0;
      prime_reg  <= 1'b0;
    end else if (accept) begin
      rad_reg   <= bus.radicand;
      acc_reg   <= '0;
      idx_reg   <= s_start;
      prime_reg <= 1'b1;
    end else if (state_reg == ITER) begin
      if (prime_reg) begin
        target_reg <= PW'(rad_reg) << FRAC;
        prime_reg  <= 1'b0;
      end else begin
        if (trial_sq <= target_reg) acc_reg <= trial;
        if (idx_reg != '0) idx_reg <= idx_reg - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sqrt_from_location.sv
module tb_sqrt_from_location;
  logic clk = 1'b0;
  logic rst_;
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;

  sqrt_from_location_if #(.WIDTH(12)) bus ();

  sqrt_from_location #(.WIDTH(12), .FRAC(4)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference: largest r using only bits s..0 with r*r <= radicand*16.
  function automatic int model_root(int rad, int loc);
    int s, t, r, cap;
    s   = (loc + 4 > 7) ? 7 : loc + 4;
    t   = rad * 16;
    cap = (1 << (s + 1)) - 1;
    r   = 0;
    while ((r + 1) * (r + 1) <= t && r + 1 <= cap) r++;
    return r;
  endfunction

  function automatic int model_lat(int loc);
    return ((loc + 4 > 7) ? 7 : loc + 4) + 2;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-level behavioural model: accepted request -> busy for s+2 cycles,
  // then one done cycle carrying the model root.
  logic m_busy, m_done;
  int   m_root, m_left, m_pending;

  always @(posedge clk) begin
    if (rst_) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_root <= 0; m_left <= 0;
    end else if (bus.start && !m_busy) begin
      m_busy    <= 1'b1;
      m_done    <= 1'b0;
      m_left    <= model_lat(int'(bus.location));
      m_pending <= model_root(int'(bus.radicand), int'(bus.location));
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_root <= m_pending;
      end
      m_left <= m_left - 1;
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", int'(bus.busy), int'(m_busy));
      check("cyc_done", int'(bus.done), int'(m_done));
      if (!m_busy) check("cyc_root", int'(bus.root), m_root);
    end
  end

  // Called at a negedge with the DUT in IDLE or DONE.
  task automatic run_op(int rad, int loc, int exp_root, int exp_lat, bit glitch);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    check("model_root", model_root(rad, loc), exp_root);
    bus.start = 1'b1; bus.radicand = 12'(rad); bus.location = 6'(loc);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done) begin seen = 1'b1; break; end
      bus.start = glitch && (lat == 2);
      if (bus.start) begin bus.radicand = 12'hFFF; bus.location = 6'd4; end
    end
    check("done_seen", int'(seen), 1);
    check("latency", lat, exp_lat);
    check("root", int'(bus.root), exp_root);
    $display("op rad=0x%03h loc=%0d root=0x%03h lat=%0d", rad, loc, bus.root, lat);
  endtask

  initial begin
    int rad, loc, ip, p;
    rst_ = 1'b1; bus.start = 1'b0; bus.radicand = '0; bus.location = '0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_root", int'(bus.root), 0);
    rst_ = 1'b0;
    @(negedge clk);

    run_op(12'h040, 1,  12'h020, 7, 1'b0);
    run_op(12'hFFF, 4,  12'h0FF, 9, 1'b0);   // back-to-back from DONE
    run_op(12'h008, 0,  12'h00B, 6, 1'b0);
    run_op(12'h000, 0,  12'h000, 6, 1'b0);
    run_op(12'h010, 0,  12'h010, 6, 1'b0);
    run_op(12'hFFF, 0,  12'h01F, 6, 1'b0);   // seed too small: saturates
    run_op(12'h040, 63, 12'h020, 9, 1'b0);   // oversized seed clamps
    run_op(12'h040, 1,  12'h020, 7, 1'b1);   // start pulse mid-ITER ignored
    @(negedge clk);
    check("idle_hold_root", int'(bus.root), 12'h020);

    // Reset during the 3rd ITER cycle aborts the operation
    bus.start = 1'b1; bus.radicand = 12'hFFF; bus.location = 6'd4;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst_ = 1'b1;
    @(posedge clk); @(negedge clk);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_root", int'(bus.root), 0);
    $display("abort busy=%0b done=%0b root=0x%03h", bus.busy, bus.done, bus.root);
    // Reset wins over a simultaneous start
    bus.start = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_prio_busy", int'(bus.busy), 0);
    bus.start = 1'b0; rst_ = 1'b0;
    repeat (12) @(negedge clk);
    run_op(12'h040, 1, 12'h020, 7, 1'b0);

    for (int n = 0; n < 100; n++) begin
      rad = int'($urandom_range(0, 4095));
      ip  = rad >> 4;
      p   = 0;
      for (int b = 0; b < 8; b++) if (ip[b]) p = b;
      loc = (ip == 0) ? 0 : (p + 1) / 2;
      run_op(rad, loc, model_root(rad, loc), model_lat(loc), n[0]);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sqrt_from_location.md
SQRT_FROM_LOCATION -- requirements
Module: sqrt_from_location

Interface
REQ-001 Parameter WIDTH, default 12: radicand and root width, unsigned fixed point.
REQ-002 Parameter FRAC, default 4: fractional bits of radicand and root.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst_  input  1: reset, synchronous and active-high (rst_=1 resets).
REQ-005 start  input  1: request; sampled on rising edges.
REQ-006 radicand  input  WIDTH: unsigned Q(WIDTH-FRAC).FRAC operand.
REQ-007 location  input  6: leading-bit seed from the last-set-bit detector, equal to ceil(p/2) where p is the MSB index of radicand>>FRAC (0 when that integer part is 0).
REQ-008 busy  output  1: high while iterating.
REQ-009 done  output  1: one-cycle pulse; root valid.
REQ-010 root  output  WIDTH: unsigned Q(WIDTH-FRAC).FRAC square root.

Function
REQ-011 Result SHALL be root = floor(sqrt(radicand << FRAC)), zero-extended to WIDTH, when location meets REQ-007.
REQ-012 States SHALL be IDLE, ITER, DONE.
REQ-013 start SHALL be accepted in IDLE or DONE; start in ITER is ignored, with no effect on the operation in flight.
REQ-014 On acceptance: latch radicand; clear the root accumulator; set bit index s = min(location + FRAC, RMAX), where RMAX = ceil((WIDTH+FRAC)/2) - 1 (7 at defaults); go to ITER.
REQ-015 ITER SHALL resolve exactly one root bit per cycle, from index s down to 0.
REQ-016 At each bit k: trial = acc | (1<<k); if trial*trial <= (radicand<<FRAC), acc = trial; otherwise acc is unchanged.
REQ-017 Intermediate products SHALL use at least 2*(RMAX+1) bits, with no truncation.
REQ-018 After bit 0 is resolved, go to DONE; done=1 for exactly that one cycle.
REQ-019 DONE SHALL go to IDLE next cycle, or to ITER if start=1 (back-to-back, no bubble).
REQ-020 Latency: done SHALL be high in the cycle starting s+2 rising edges after the accepting edge.
REQ-021 busy SHALL be 1 exactly while in ITER.
REQ-022 done SHALL be 0 except in DONE.
REQ-023 root SHALL hold the final value from DONE until the next accepted start.
REQ-024 root SHALL be don't-care while busy=1.
REQ-025 If location is too small for the operand, root SHALL be the largest value using only bits s..0 whose square <= radicand<<FRAC (saturated, no error flag).
REQ-026 location > RMAX-FRAC SHALL clamp via REQ-014.

Reset
REQ-027 With rst_=1 at a rising edge, state=IDLE, busy=0, done=0, root=0, and the accumulator and bit index SHALL clear.
REQ-028 rst_ SHALL have priority over start, including when both are high on the same edge.
REQ-029 Reset mid-ITER SHALL abort the operation; no done pulse SHALL follow.
REQ-030 The first start after reset deasserts SHALL be accepted normally.

Verification
REQ-031 radicand=0x040 (4.0), location=1 -> s=5; done 7 edges after start; root=0x020 (2.0).
REQ-032 radicand=0xFFF, location=4 -> s clamps to 7; done after 9 edges; root=0x0FF (15.9375).
REQ-033 radicand=0x008 (0.5), location=0 -> s=4; root=0x00B (0.6875); done after 6 edges.
REQ-034 radicand=0x000, location=0 -> root=0x000, done after 6 edges; radicand=0x010 (1.0), location=0 -> root=0x010.
REQ-035 Reset abort: start 0xFFF; assert rst_ on the 3rd ITER cycle -> next cycle busy=0, done=0, root=0, no done pulse; a new start with 0x040 yields 0x020.
REQ-036 Handshake: start pulses during ITER are ignored (root/latency unchanged); start held high in DONE launches the next operation with no IDLE cycle; 100 random radicands with matching location match REQ-011.
